phase_sequencer: RTL and testbench

Parametrised instruction-phase sequencer, the successor to `status_counter`. It steps the CPU through fetch (IF), source-operand fetch (FF), execute (EX), destination store (TF) and interrupt-entry (IT) phases. Each phase is presented to `isr_decoder` as a one-hot phase strobe. Unlike its predecessor, it supports:
- a configurable execute length;
- memory wait states driven by `ACK`;
- a bus-timeout recovery path;
- an execute hold;
- a terminal halt state.

---
 rtl/phase_seq_pkg.sv | 22 ++
 rtl/phase_sequencer_wait_timer.sv | 28 ++
 rtl/phase_sequencer.sv | 161 ++++++++++++++++
 tb/tb_phase_sequencer.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/phase_seq_pkg.sv
// Shared state encoding for the instruction-phase sequencer.
// EX phases occupy a contiguous block starting at S_EX_BASE, so the state width depends on EX_CYCLES.
package phase_seq_pkg;

    localparam int S_IF0     = 0;
    localparam int S_IF1     = 1;
    localparam int S_FF0     = 2;
    localparam int S_FF1     = 3;
    localparam int S_FF2     = 4;
    localparam int S_TF0     = 5;
    localparam int S_TF1     = 6;
    localparam int S_IT0     = 7;
    localparam int S_IT1     = 8;
    localparam int S_IT2     = 9;
    localparam int S_HALT    = 10;
    localparam int S_EX_BASE = 11;

    function automatic int state_w(input int ex_cycles);
        return $clog2(S_EX_BASE + ex_cycles);
    endfunction

endpackage

// File: rtl/phase_sequencer_wait_timer.sv
// Saturating wait-state counter with clear, increment and timeout compare.
// Clear has priority over increment.
module wait_timer #(
    parameter int TMO_W   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_expired
);

    logic [TMO_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != {TMO_W{1'b1}})) begin
            r_cnt <= r_cnt + TMO_W'(1);
        end
    end

    assign o_expired = (r_cnt == TMO_W'(TIMEOUT));

endmodule

// File: rtl/phase_sequencer.sv
// Instruction-phase sequencer: IF/FF/EX/TF/IT phase FSM with wait states,
// bus timeout recovery, execute hold and terminal halt. Outputs decode from state or are registered.
module phase_sequencer
    import phase_seq_pkg::*;
#(
    parameter int EX_CYCLES = 2,
    parameter int TMO_W     = 4,
    parameter int TIMEOUT   = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ITA,
    input  logic                 ACK,
    input  logic                 FROM_D,
    input  logic                 TO_D,
    input  logic                 EX_HOLD,
    output logic [1:0]           IF_PH,
    output logic [2:0]           FF_PH,
    output logic [1:0]           TF_PH,
    output logic [EX_CYCLES-1:0] EX_PH,
    output logic [2:0]           IT_PH,
    output logic                 MREQ,
    output logic                 INSTR_DONE,
    output logic                 BUS_ERR,
    output logic                 HALTED
);

    localparam int SW = state_w(EX_CYCLES);

    localparam logic [SW-1:0] ST_IF0  = SW'(S_IF0);
    localparam logic [SW-1:0] ST_IF1  = SW'(S_IF1);
    localparam logic [SW-1:0] ST_FF0  = SW'(S_FF0);
    localparam logic [SW-1:0] ST_FF1  = SW'(S_FF1);
    localparam logic [SW-1:0] ST_FF2  = SW'(S_FF2);
    localparam logic [SW-1:0] ST_TF0  = SW'(S_TF0);
    localparam logic [SW-1:0] ST_TF1  = SW'(S_TF1);
    localparam logic [SW-1:0] ST_IT0  = SW'(S_IT0);
    localparam logic [SW-1:0] ST_IT1  = SW'(S_IT1);
    localparam logic [SW-1:0] ST_IT2  = SW'(S_IT2);
    localparam logic [SW-1:0] ST_HALT = SW'(S_HALT);
    localparam logic [SW-1:0] ST_EX0  = SW'(S_EX_BASE);
    localparam logic [SW-1:0] ST_EXL  = SW'(S_EX_BASE + EX_CYCLES - 1);

    logic [SW-1:0] r_state;
    logic [SW-1:0] w_next;
    logic          r_done;
    logic          r_berr;
    logic          w_done_nxt;
    logic          w_berr_nxt;
    logic          w_in_wait;
    logic          w_expired;

    assign w_in_wait = (r_state == ST_IF1) || (r_state == ST_FF1) ||
                       (r_state == ST_TF1) || (r_state == ST_IT1);

    // Counter is held clear outside wait phases, so every wait phase starts at zero.
    wait_timer #(
        .TMO_W   (TMO_W),
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk       (clk),
        .reset     (reset),
        .i_clr     (!w_in_wait),
        .i_inc     (w_in_wait && !ACK),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IF0;
            r_done  <= 1'b0;
            r_berr  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= w_done_nxt;
            r_berr  <= w_berr_nxt;
        end
    end

    // ACK is tested before the timeout so an acknowledge on the expiry cycle still advances normally.
    always_comb begin
        w_next     = r_state;
        w_done_nxt = 1'b0;
        w_berr_nxt = 1'b0;
        case (r_state)
            ST_IF0: w_next = ST_IF1;
            ST_IF1: begin
                if (ACK) begin
                    w_next = FROM_D ? ST_FF0 : ST_EX0;
                end else if (w_expired) begin
                    w_next     = ST_IT0;
                    w_berr_nxt = 1'b1;
                end
            end
            ST_FF0: w_next = ST_FF1;
            ST_FF1: begin
                if (ACK) begin
                    w_next = ST_FF2;
                end else if (w_expired) begin
                    w_next     = ST_IT0;
                    w_berr_nxt = 1'b1;
                end
            end
            ST_FF2: w_next = ST_EX0;
            ST_TF0: w_next = ST_TF1;
            ST_TF1: begin
                if (ACK) begin
                    w_next     = ITA ? ST_IT0 : ST_IF0;
                    w_done_nxt = 1'b1;
                end else if (w_expired) begin
                    w_next     = ST_IT0;
                    w_berr_nxt = 1'b1;
                end
            end
            ST_IT0: w_next = ST_IT1;
            ST_IT1: begin
                if (ACK) begin
                    w_next = ST_IT2;
                end else if (w_expired) begin
                    w_next     = ST_HALT;
                    w_berr_nxt = 1'b1;
                end
            end
            ST_IT2:  w_next = ST_IF0;
            ST_HALT: w_next = ST_HALT;
            default: begin
                if ((r_state >= ST_EX0) && (r_state <= ST_EXL)) begin
                    if (!EX_HOLD) begin
                        if (r_state != ST_EXL) begin
                            w_next = r_state + SW'(1);
                        end else if (TO_D) begin
                            w_next = ST_TF0;
                        end else begin
                            w_next     = ITA ? ST_IT0 : ST_IF0;
                            w_done_nxt = 1'b1;
                        end
                    end
                end else begin
                    w_next = ST_IF0;
                end
            end
        endcase
    end

    always_comb begin
        IF_PH = {r_state == ST_IF1, r_state == ST_IF0};
        FF_PH = {r_state == ST_FF2, r_state == ST_FF1, r_state == ST_FF0};
        TF_PH = {r_state == ST_TF1, r_state == ST_TF0};
        IT_PH = {r_state == ST_IT2, r_state == ST_IT1, r_state == ST_IT0};
        EX_PH = '0;
        for (int k = 0; k < EX_CYCLES; k++) begin
            EX_PH[k] = (r_state == SW'(S_EX_BASE + k));
        end
    end

    assign MREQ       = w_in_wait;
    assign HALTED     = (r_state == ST_HALT);
    assign INSTR_DONE = r_done;
    assign BUS_ERR    = r_berr;

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer: default build (EX=2, TIMEOUT=15) and an EX=5 build for hold tests.
module tb_phase_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, ITA, ACK, FROM_D, TO_D, EX_HOLD;
    logic [1:0] IF_PH;
    logic [2:0] FF_PH;
    logic [1:0] TF_PH;
    logic [1:0] EX_PH;
    logic [2:0] IT_PH;
    logic       MREQ, INSTR_DONE, BUS_ERR, HALTED;

    logic       b_reset, b_hold;
    logic [1:0] b_if;
    logic [2:0] b_ff;
    logic [1:0] b_tf;
    logic [4:0] b_ex;
    logic [2:0] b_it;
    logic       b_mreq, b_done, b_berr, b_halted;

    phase_sequencer #(.EX_CYCLES(2), .TMO_W(4), .TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .ITA(ITA), .ACK(ACK), .FROM_D(FROM_D), .TO_D(TO_D),
        .EX_HOLD(EX_HOLD), .IF_PH(IF_PH), .FF_PH(FF_PH), .TF_PH(TF_PH), .EX_PH(EX_PH),
        .IT_PH(IT_PH), .MREQ(MREQ), .INSTR_DONE(INSTR_DONE), .BUS_ERR(BUS_ERR), .HALTED(HALTED)
    );

    phase_sequencer #(.EX_CYCLES(5), .TMO_W(4), .TIMEOUT(15)) dut5 (
        .clk(clk), .reset(b_reset), .ITA(1'b0), .ACK(1'b1), .FROM_D(1'b0), .TO_D(1'b0),
        .EX_HOLD(b_hold), .IF_PH(b_if), .FF_PH(b_ff), .TF_PH(b_tf), .EX_PH(b_ex),
        .IT_PH(b_it), .MREQ(b_mreq), .INSTR_DONE(b_done), .BUS_ERR(b_berr), .HALTED(b_halted)
    );

    // Strobe order: {IF[1:0], FF[2:0], TF[1:0], EX[1:0], IT[2:0]}
    localparam logic [11:0] P_IF0  = 12'b01_000_00_00_000;
    localparam logic [11:0] P_IF1  = 12'b10_000_00_00_000;
    localparam logic [11:0] P_FF0  = 12'b00_001_00_00_000;
    localparam logic [11:0] P_FF1  = 12'b00_010_00_00_000;
    localparam logic [11:0] P_FF2  = 12'b00_100_00_00_000;
    localparam logic [11:0] P_TF0  = 12'b00_000_01_00_000;
    localparam logic [11:0] P_TF1  = 12'b00_000_10_00_000;
    localparam logic [11:0] P_EX0  = 12'b00_000_00_01_000;
    localparam logic [11:0] P_EX1  = 12'b00_000_00_10_000;
    localparam logic [11:0] P_IT0  = 12'b00_000_00_00_001;
    localparam logic [11:0] P_IT1  = 12'b00_000_00_00_010;
    localparam logic [11:0] P_IT2  = 12'b00_000_00_00_100;
    localparam logic [11:0] P_HALT = 12'b00_000_00_00_000;

    logic [31:0] w_obs_a, w_obs_b;
    assign w_obs_a = {16'h0, IF_PH, FF_PH, TF_PH, EX_PH, IT_PH, MREQ, INSTR_DONE, BUS_ERR, HALTED};
    assign w_obs_b = {13'h0, b_if, b_ff, b_tf, b_ex, b_it, b_mreq, b_done, b_berr, b_halted};

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [11:0] p, input logic d, input logic b, input logic h);
        logic mreq;
        mreq = (p == P_IF1) || (p == P_FF1) || (p == P_TF1) || (p == P_IT1);
        return {16'h0, p, mreq, d, b, h};
    endfunction

    function automatic logic [31:0] mk_b(input logic [1:0] ifp, input logic [4:0] ex, input logic d);
        return {13'h0, ifp, 3'b000, 2'b00, ex, 3'b000, (ifp == 2'b10), d, 1'b0, 1'b0};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Inputs are applied while in the current state; the check sees the state after the next edge.
    task automatic vec(input string tag, input logic a, input logic fr, input logic to,
                       input logic it, input logic h, input logic [31:0] e);
        ACK = a; FROM_D = fr; TO_D = to; ITA = it; EX_HOLD = h;
        step();
        check(tag, w_obs_a, e);
    endtask

    task automatic vec_b(input string tag, input logic h, input logic [31:0] e);
        b_hold = h;
        step();
        check(tag, w_obs_b, e);
        check({tag, "_onehot"}, 32'($countones({b_if, b_ff, b_tf, b_ex, b_it})), 32'd1);
    endtask

    initial begin
        logic [11:0] seq [4];
        seq = '{P_IF1, P_EX0, P_EX1, P_IF0};

        reset = 1'b1; ACK = 1'b1; ITA = 1'b0; FROM_D = 1'b0; TO_D = 1'b0; EX_HOLD = 1'b0;
        b_reset = 1'b1; b_hold = 1'b0;
        step();
        step();
        check("reset_a", w_obs_a, mk(P_IF0, 0, 0, 0));
        check("reset_b", w_obs_b, mk_b(2'b01, 5'b0, 0));
        reset = 1'b0;

        // Zero-wait short instructions, period 4
        for (int i = 0; i < 8; i++)
            vec("loop", 1, 0, 0, 0, 0, mk(seq[i % 4], (seq[i % 4] == P_IF0), 0, 0));

        // FROM_D and TO_D with two wait cycles in FF1: 11-cycle instruction
        vec("fd_if1", 1, 1, 1, 0, 0, mk(P_IF1, 0, 0, 0));
        vec("fd_ff0", 1, 1, 1, 0, 0, mk(P_FF0, 0, 0, 0));
        vec("fd_ff1a", 0, 1, 1, 0, 0, mk(P_FF1, 0, 0, 0));
        vec("fd_ff1b", 0, 1, 1, 0, 0, mk(P_FF1, 0, 0, 0));
        vec("fd_ff1c", 0, 1, 1, 0, 0, mk(P_FF1, 0, 0, 0));
        vec("fd_ff2", 1, 1, 1, 0, 0, mk(P_FF2, 0, 0, 0));
        vec("fd_ex0", 1, 1, 1, 0, 0, mk(P_EX0, 0, 0, 0));
        vec("fd_ex1", 1, 1, 1, 0, 0, mk(P_EX1, 0, 0, 0));
        vec("fd_tf0", 1, 1, 1, 0, 0, mk(P_TF0, 0, 0, 0));
        vec("fd_tf1", 1, 1, 1, 0, 0, mk(P_TF1, 0, 0, 0));
        vec("fd_if0", 1, 1, 1, 0, 0, mk(P_IF0, 1, 0, 0));

        // Interrupt entry at instruction end; no done after IT2, no nesting
        vec("it_if1", 1, 0, 0, 0, 0, mk(P_IF1, 0, 0, 0));
        vec("it_ex0", 1, 0, 0, 0, 0, mk(P_EX0, 0, 0, 0));
        vec("it_ex1", 1, 0, 0, 1, 0, mk(P_EX1, 0, 0, 0));
        vec("it_it0", 1, 0, 0, 1, 0, mk(P_IT0, 1, 0, 0));
        vec("it_it1", 1, 0, 0, 1, 0, mk(P_IT1, 0, 0, 0));
        vec("it_it2", 1, 0, 0, 1, 0, mk(P_IT2, 0, 0, 0));
        vec("it_if0", 1, 0, 0, 1, 0, mk(P_IF0, 0, 0, 0));

        // Timeout in IF1 -> IT0, then timeout in IT1 -> HALT
        vec("to_if1_0", 0, 0, 0, 0, 0, mk(P_IF1, 0, 0, 0));
        for (int i = 1; i <= 15; i++)
            vec("to_if1_wait", 0, 0, 0, 0, 0, mk(P_IF1, 0, 0, 0));
        vec("to_it0", 0, 0, 0, 0, 0, mk(P_IT0, 0, 1, 0));
        vec("to_it1_0", 0, 0, 0, 0, 0, mk(P_IT1, 0, 0, 0));
        for (int i = 1; i <= 15; i++)
            vec("to_it1_wait", 0, 0, 0, 0, 0, mk(P_IT1, 0, 0, 0));
        vec("to_halt", 0, 0, 0, 0, 0, mk(P_HALT, 0, 1, 1));
        vec("halt_hold", 1, 0, 0, 1, 0, mk(P_HALT, 0, 0, 1));
        vec("halt_hold2", 1, 1, 1, 0, 1, mk(P_HALT, 0, 0, 1));

        reset = 1'b1;
        vec("reset_halt", 1, 0, 0, 0, 0, mk(P_IF0, 0, 0, 0));
        reset = 1'b0;

        // ACK on the expiry cycle wins; EX_HOLD outside EX has no effect
        vec("ackw_if1", 0, 0, 0, 0, 1, mk(P_IF1, 0, 0, 0));
        for (int i = 1; i <= 15; i++)
            vec("ackw_wait", 0, 0, 0, 0, 1, mk(P_IF1, 0, 0, 0));
        vec("ackw_ex0", 1, 0, 0, 0, 0, mk(P_EX0, 0, 0, 0));
        vec("ackw_ex1", 1, 0, 0, 0, 0, mk(P_EX1, 0, 0, 0));
        vec("ackw_if0", 1, 0, 0, 0, 0, mk(P_IF0, 1, 0, 0));

        // Reset mid-instruction
        vec("mid_if1", 1, 0, 0, 0, 0, mk(P_IF1, 0, 0, 0));
        reset = 1'b1;
        vec("mid_reset", 1, 0, 0, 0, 0, mk(P_IF0, 0, 0, 0));
        reset = 1'b0;

        // EX_CYCLES=5 with EX2 held for three extra cycles
        b_reset = 1'b0;
        vec_b("b_if1", 0, mk_b(2'b10, 5'b00000, 0));
        vec_b("b_ex0", 0, mk_b(2'b00, 5'b00001, 0));
        vec_b("b_ex1", 0, mk_b(2'b00, 5'b00010, 0));
        vec_b("b_ex2", 0, mk_b(2'b00, 5'b00100, 0));
        vec_b("b_ex2_h1", 1, mk_b(2'b00, 5'b00100, 0));
        vec_b("b_ex2_h2", 1, mk_b(2'b00, 5'b00100, 0));
        vec_b("b_ex2_h3", 1, mk_b(2'b00, 5'b00100, 0));
        vec_b("b_ex3", 0, mk_b(2'b00, 5'b01000, 0));
        vec_b("b_ex4", 0, mk_b(2'b00, 5'b10000, 0));
        vec_b("b_if0", 0, mk_b(2'b01, 5'b00000, 1));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
